// File: rtl/pe_wsmac.sv
// pe_wsmac: weight-stationary fixed-point MAC processing element.
// Activations flow west->east, weights and partial sums flow north->south.
// The weight is double-buffered: a shadow register is loaded from the north
// and promoted to the active register on a switch request.
// Build option: define PE_SATURATE_EN to clamp out-of-range sums to the
// signed PSUM_WIDTH limits; otherwise the sum wraps (low bits kept).
module pe_wsmac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int PSUM_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [PSUM_WIDTH-1:0] pe_psum_in,
  input  logic signed [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                         pe_accept_w_in,
  input  logic signed [DATA_WIDTH-1:0] pe_input_in,
  input  logic                         pe_valid_in,
  input  logic                         pe_switch_in,
  output logic signed [PSUM_WIDTH-1:0] pe_psum_out,
  output logic signed [DATA_WIDTH-1:0] pe_weight_out,
  output logic                         pe_accept_w_out,
  output logic signed [DATA_WIDTH-1:0] pe_input_out,
  output logic                         pe_valid_out,
  output logic                         pe_switch_out,
  output logic                         pe_switch_err,
  output logic                         pe_ovf
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PSUM_WIDTH + DATA_WIDTH + 1;

  localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

  // Shadow buffer occupancy: EMPTY means nothing new to promote.
  typedef enum logic {
    BUF_EMPTY  = 1'b0,
    BUF_LOADED = 1'b1
  } buf_state_e;

  buf_state_e                  buf_q,    buf_d;
  logic signed [DATA_WIDTH-1:0] active_q, active_d;
  logic signed [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                         err_q,    err_d;
  logic                         ovf_q,    ovf_d;
  logic signed [PSUM_WIDTH-1:0] psum_q,   psum_d;
  logic signed [DATA_WIDTH-1:0] wout_q,   wout_d;
  logic signed [DATA_WIDTH-1:0] xout_q,   xout_d;
  logic                         acc_q, vld_q, sw_q;

  logic                         do_switch;
  logic signed [DATA_WIDTH-1:0] w_eff;
  logic signed [PROD_W-1:0]     prod;
  logic signed [PROD_W-1:0]     scaled;
  logic        [SUM_W-1:0]      sum;
  logic                         sum_ovf;
  logic        [PSUM_WIDTH-1:0] result;

  // A switch only takes effect when a fresh weight is waiting; in that cycle
  // the shadow value is bypassed straight into the multiplier.
  assign do_switch = pe_switch_in && (buf_q == BUF_LOADED);
  assign w_eff     = do_switch ? shadow_q : active_q;

  // Fixed-point MAC datapath: full-width product, floor rescale, wide add.
  always_comb begin
    prod   = $signed({{DATA_WIDTH{pe_input_in[DATA_WIDTH-1]}}, pe_input_in})
           * $signed({{DATA_WIDTH{w_eff[DATA_WIDTH-1]}}, w_eff});
    scaled = prod >>> FRAC_BITS;
    sum    = {{(SUM_W-PROD_W){scaled[PROD_W-1]}}, scaled}
           + {{(SUM_W-PSUM_WIDTH){pe_psum_in[PSUM_WIDTH-1]}}, pe_psum_in};
    // In range only if all bits above the PSUM sign bit replicate it.
    sum_ovf = !((&sum[SUM_W-1:PSUM_WIDTH-1]) || !(|sum[SUM_W-1:PSUM_WIDTH-1]));
`ifdef PE_SATURATE_EN
    if (sum_ovf) result = sum[SUM_W-1] ? PSUM_MIN : PSUM_MAX;
    else         result = sum[PSUM_WIDTH-1:0];
`else
    result = sum[PSUM_WIDTH-1:0];
`endif
  end

  // Next-state for the weight buffer, sticky flags and south/east outputs.
  always_comb begin
    buf_d    = buf_q;
    active_d = active_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    psum_d   = '0;
    xout_d   = xout_q;
    wout_d   = '0;

    // Promotion consumes the OLD shadow; a same-cycle accept refills it.
    if (do_switch) begin
      active_d = shadow_q;
      buf_d    = BUF_EMPTY;
    end
    if (pe_switch_in && (buf_q == BUF_EMPTY)) err_d = 1'b1;
    if (pe_accept_w_in) begin
      shadow_d = pe_weight_in;
      buf_d    = BUF_LOADED;
      wout_d   = pe_weight_in;
    end

    if (pe_valid_in) begin
      psum_d = result;
      xout_d = pe_input_in;
      if (sum_ovf) ovf_d = 1'b1;
    end
  end

  // All state, with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= BUF_EMPTY;
      active_q <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      psum_q   <= '0;
      wout_q   <= '0;
      xout_q   <= '0;
      acc_q    <= 1'b0;
      vld_q    <= 1'b0;
      sw_q     <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      psum_q   <= psum_d;
      wout_q   <= wout_d;
      xout_q   <= xout_d;
      acc_q    <= pe_accept_w_in;
      vld_q    <= pe_valid_in;
      sw_q     <= pe_switch_in;
    end
  end

  assign pe_psum_out     = psum_q;
  assign pe_weight_out   = wout_q;
  assign pe_accept_w_out = acc_q;
  assign pe_input_out    = xout_q;
  assign pe_valid_out    = vld_q;
  assign pe_switch_out   = sw_q;
  assign pe_switch_err   = err_q;
  assign pe_ovf          = ovf_q;

endmodule

// File: tb/tb_pe_wsmac.sv
// tb_pe_wsmac: directed test-plan cases plus randomized traffic, every cycle
// checked against an arithmetic reference model of the PE.
module tb_pe_wsmac;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [PW-1:0] psum_in;
  logic [DW-1:0] weight_in, input_in;
  logic accept_in, valid_in, switch_in;
  logic [PW-1:0] psum_out;
  logic [DW-1:0] weight_out, input_out;
  logic accept_out, valid_out, switch_out, switch_err, ovf;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] m_act, m_shd;
  bit m_ldd, m_err, m_ovf;
  logic [PW-1:0] e_psum;
  logic [DW-1:0] e_wout, e_xout;
  bit e_acc, e_vld, e_sw;

  always #5 clk = ~clk;

  pe_wsmac #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .PSUM_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .pe_psum_in(psum_in), .pe_weight_in(weight_in), .pe_accept_w_in(accept_in),
    .pe_input_in(input_in), .pe_valid_in(valid_in), .pe_switch_in(switch_in),
    .pe_psum_out(psum_out), .pe_weight_out(weight_out), .pe_accept_w_out(accept_out),
    .pe_input_out(input_out), .pe_valid_out(valid_out), .pe_switch_out(switch_out),
    .pe_switch_err(switch_err), .pe_ovf(ovf)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one clock of the PE expressed as plain integer math.
  task automatic model(input bit r, a, input logic [DW-1:0] w, input bit s, v,
                       input logic [DW-1:0] x, input logic [PW-1:0] ps);
    longint xi, wi, pi, prod, sum, lim_hi, lim_lo;
    logic [DW-1:0] weff;
    if (r) begin
      m_act = '0; m_shd = '0; m_ldd = 0; m_err = 0; m_ovf = 0;
      e_psum = '0; e_wout = '0; e_xout = '0; e_acc = 0; e_vld = 0; e_sw = 0;
      return;
    end
    weff = (s && m_ldd) ? m_shd : m_act;
    lim_hi = (64'sd1 <<< (PW-1)) - 1;
    lim_lo = -(64'sd1 <<< (PW-1));
    if (v) begin
      xi = longint'($signed(x));
      wi = longint'($signed(weff));
      pi = longint'($signed(ps));
      prod = xi * wi;
      // floor division by 2^FB
      sum = (prod >= 0) ? prod / (64'sd1 <<< FB)
                        : -((-prod + (64'sd1 <<< FB) - 1) / (64'sd1 <<< FB));
      sum = sum + pi;
      if (sum > lim_hi || sum < lim_lo) begin
        m_ovf = 1;
`ifdef PE_SATURATE_EN
        sum = (sum > lim_hi) ? lim_hi : lim_lo;
`endif
      end
      e_psum = sum[PW-1:0];
      e_xout = x;
    end else begin
      e_psum = '0;
    end
    e_vld = v; e_sw = s; e_acc = a;
    e_wout = a ? w : '0;
    if (s && !m_ldd) m_err = 1;
    if (s && m_ldd) begin m_act = m_shd; m_ldd = 0; end
    if (a) begin m_shd = w; m_ldd = 1; end
  endtask

  // Drive one cycle, advance the model, then check every output #1 after the edge.
  task automatic cyc(input bit r, a, input logic [DW-1:0] w, input bit s, v,
                     input logic [DW-1:0] x, input logic [PW-1:0] ps);
    rst = r; accept_in = a; weight_in = w; switch_in = s;
    valid_in = v; input_in = x; psum_in = ps;
    model(r, a, w, s, v, x, ps);
    @(posedge clk); #1;
    chk("psum_out",   psum_out,   e_psum);
    chk("weight_out", weight_out, e_wout);
    chk("accept_out", {15'd0, accept_out}, {15'd0, e_acc});
    chk("input_out",  input_out,  e_xout);
    chk("valid_out",  {15'd0, valid_out},  {15'd0, e_vld});
    chk("switch_out", {15'd0, switch_out}, {15'd0, e_sw});
    chk("switch_err", {15'd0, switch_err}, {15'd0, m_err});
    chk("ovf",        {15'd0, ovf},        {15'd0, m_ovf});
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic do_rst();
    cyc(1, 0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1; accept_in = 0; weight_in = '0; switch_in = 0;
    valid_in = 0; input_in = '0; psum_in = '0;

    // reset state
    do_rst();
    chk("rst_psum", psum_out, 16'h0000);
    chk("rst_err",  {15'd0, switch_err}, 16'h0000);
    chk("rst_ovf",  {15'd0, ovf}, 16'h0000);

    // load, switch and MAC
    cyc(0, 1, 16'h0200, 0, 0, '0, '0);
    chk("tp1_wout", weight_out, 16'h0200);
    chk("tp1_acc",  {15'd0, accept_out}, 16'h0001);
    cyc(0, 0, '0, 1, 1, 16'h0180, 16'h0100);
    chk("tp1_psum", psum_out, 16'h0400);
    chk("tp1_vld",  {15'd0, valid_out}, 16'h0001);
    chk("tp1_sw",   {15'd0, switch_out}, 16'h0001);
    chk("tp1_err",  {15'd0, switch_err}, 16'h0000);
    idle();
    chk("tp1_hold_in", input_out, 16'h0180);

    // switch without a loaded shadow
    do_rst();
    cyc(0, 0, '0, 1, 0, '0, '0);
    cyc(0, 0, '0, 0, 1, 16'h0100, '0);
    chk("tp2_psum", psum_out, 16'h0000);
    chk("tp2_err",  {15'd0, switch_err}, 16'h0001);
    repeat (3) idle();
    chk("tp2_err_sticky", {15'd0, switch_err}, 16'h0001);

    // overflow
    do_rst();
    cyc(0, 1, 16'h0200, 0, 0, '0, '0);
    cyc(0, 0, '0, 1, 0, '0, '0);
    cyc(0, 0, '0, 0, 1, 16'h7F00, '0);
`ifdef PE_SATURATE_EN
    chk("tp3_psum", psum_out, 16'h7FFF);
`else
    chk("tp3_psum", psum_out, 16'hFE00);
`endif
    chk("tp3_ovf", {15'd0, ovf}, 16'h0001);
    idle();
    chk("tp3_ovf_sticky", {15'd0, ovf}, 16'h0001);

    // simultaneous accept and switch
    do_rst();
    cyc(0, 1, 16'h0100, 0, 0, '0, '0);
    cyc(0, 1, 16'h0300, 1, 0, '0, '0);
    cyc(0, 0, '0, 0, 1, 16'h0100, '0);
    chk("tp4_psum_a", psum_out, 16'h0100);
    cyc(0, 0, '0, 1, 0, '0, '0);
    cyc(0, 0, '0, 0, 1, 16'h0100, '0);
    chk("tp4_psum_b", psum_out, 16'h0300);
    chk("tp4_err", {15'd0, switch_err}, 16'h0000);

    // negative truncation
    do_rst();
    cyc(0, 1, 16'hFFFF, 0, 0, '0, '0);
    cyc(0, 0, '0, 1, 0, '0, '0);
    cyc(0, 0, '0, 0, 1, 16'h0001, '0);
    chk("tp5_psum", psum_out, 16'hFFFF);

    // reset mid-stream with shadow loaded
    cyc(0, 1, 16'h0100, 0, 1, 16'h0200, 16'h0010);
    cyc(0, 0, '0, 0, 1, 16'h0300, 16'h0020);
    cyc(1, 0, '0, 0, 1, 16'h0400, 16'h0030);
    chk("tp6_psum", psum_out, 16'h0000);
    chk("tp6_vld",  {15'd0, valid_out}, 16'h0000);
    chk("tp6_xout", input_out, 16'h0000);
    cyc(0, 0, '0, 1, 0, '0, '0);
    chk("tp6_err", {15'd0, switch_err}, 16'h0001);

    // randomized traffic, mixing small operands with full-range ones
    do_rst();
    for (int i = 0; i < 3000; i++) begin
      bit r, a, s, v;
      logic [DW-1:0] w, x;
      logic [PW-1:0] ps;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        w  = DW'($signed(16'($urandom_range(0, 1023))) - 16'sd512);
        x  = DW'($signed(16'($urandom_range(0, 4095))) - 16'sd2048);
        ps = PW'($signed(16'($urandom_range(0, 8191))) - 16'sd4096);
      end else begin
        w  = DW'($urandom);
        x  = DW'($urandom);
        ps = PW'($urandom);
      end
      cyc(r, a, w, s, v, x, ps);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_wsmac.md
Name: pe_wsmac

Overview:
- Parametrised weight-stationary processing element: the next generation of the systolic-array PE.
- Fixed-point MAC with configurable data, fraction and partial-sum widths, and a double-buffered weight register with an explicit shadow-valid state.
- Switching to a new weight now has fully defined, registered behaviour.
- Tiles into the systolic array: inputs flow west to east, weights and partial sums flow north to south.

Parameters:
- DATA_WIDTH, 16, width of input and weight operands (signed fixed-point).
- FRAC_BITS, 8, fractional bits of operands and psum (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- PSUM_WIDTH, 16, width of psum_in/psum_out; must be >= DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- pe_psum_in  in  PSUM_WIDTH  signed partial sum from north
- pe_weight_in  in  DATA_WIDTH  signed weight from north
- pe_accept_w_in  in  1  load pe_weight_in into shadow register this cycle
- pe_input_in  in  DATA_WIDTH  signed activation from west
- pe_valid_in  in  1  pe_input_in/pe_psum_in valid
- pe_switch_in  in  1  promote shadow weight to active
- pe_psum_out  out  PSUM_WIDTH  registered MAC result to south
- pe_weight_out  out  DATA_WIDTH  registered weight forwarded south
- pe_accept_w_out  out  1  registered pe_accept_w_in
- pe_input_out  out  DATA_WIDTH  registered activation to east
- pe_valid_out  out  1  registered pe_valid_in
- pe_switch_out  out  1  registered pe_switch_in
- pe_switch_err  out  1  sticky: switch requested with no shadow weight loaded
- pe_ovf  out  1  sticky: MAC result exceeded PSUM_WIDTH range

Behaviour:
- Reset: rst is synchronous and active-high; all registers clear on a rising clk edge with rst=1.
  - Outputs after reset: all 0, including both flags.
  - Internal state after reset: active=0, shadow=0, shadow_valid=0.
- Reset mid-operation discards the in-flight result and the loaded shadow weight.
- Weight-buffer states, encoded by shadow_valid:
  - EMPTY (0): shadow register holds no new weight.
  - LOADED (1): a new weight is waiting in the shadow register.
- Weight load:
  - pe_accept_w_in=1 writes pe_weight_in to shadow and sets shadow_valid.
  - Next cycle pe_weight_out=pe_weight_in and pe_accept_w_out=1.
  - Otherwise pe_weight_out=0 and pe_accept_w_out=0.
- Switch, when pe_switch_in=1 and shadow_valid=1:
  - The weight used this cycle is the shadow weight (bypass).
  - At the edge: active <= shadow; shadow_valid <= 0.
- Switch, when pe_switch_in=1 and shadow_valid=0:
  - active weight is unchanged.
  - pe_switch_err is set and stays set until rst.
- Simultaneous switch and accept in the same cycle:
  - Switch uses the OLD shadow contents.
  - The new weight is loaded into shadow, and shadow_valid ends at 1.
  - Error rule is evaluated against the old shadow_valid.
- pe_switch_out = pe_switch_in delayed 1 cycle, independent of pe_valid_in.
- MAC, latency 1 cycle:
  - prod = input * weight_eff, full 2*DATA_WIDTH signed.
  - scaled = prod >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
  - sum = scaled + sign-extended pe_psum_in, computed at PSUM_WIDTH+DATA_WIDTH+1 bits.
  - Result is reduced to PSUM_WIDTH per the optional feature.
  - pe_ovf is set if sum lies outside the signed PSUM_WIDTH range.
- Valid handling:
  - pe_valid_in=1: pe_psum_out <= result, pe_input_out <= pe_input_in, pe_valid_out <= 1.
  - pe_valid_in=0: pe_psum_out <= 0, pe_valid_out <= 0, pe_input_out holds its previous value.
- Back-to-back valids sustain one result per cycle, with no bubbles.

Optional Feature:
- Macro: PE_SATURATE_EN.
- Defined: an out-of-range sum clamps to the max/min signed PSUM_WIDTH value (0x7FFF/0x8000 at defaults); pe_ovf is still set.
- Undefined: the result wraps (low PSUM_WIDTH bits kept); pe_ovf is still set.

Test Plan:
- Load, switch and MAC (defaults):
  - Stimulus: accept=1, weight=0x0200, then switch=1 with valid=1, input=0x0180, psum_in=0x0100.
  - Response: next cycle psum_out=0x0400, valid_out=1, switch_out=1, switch_err=0.
- Switch without a loaded shadow:
  - Stimulus: switch=1 right after reset, then valid=1, input=0x0100.
  - Response: psum_out=0x0000 (active weight still 0); switch_err=1 and stays set.
- Overflow:
  - Stimulus: active weight=0x0200, input=0x7F00, psum_in=0.
  - With PE_SATURATE_EN: psum_out=0x7FFF, ovf=1.
  - Without PE_SATURATE_EN: psum_out=0xFE00, ovf=1.
- Simultaneous accept and switch:
  - Stimulus: shadow=0x0100 LOADED, then same cycle switch=1, accept=1, weight=0x0300; next cycle valid=1, input=0x0100, psum_in=0.
  - Response: psum_out=0x0100; a second switch then yields 0x0300 for the same input.
- Negative truncation:
  - Stimulus: weight=0xFFFF (-1/256), input=0x0001, psum_in=0.
  - Response: psum_out=0xFFFF (floor of -1/65536).
- Reset mid-stream:
  - Stimulus: assert rst during a valid burst with shadow LOADED.
  - Response: next cycle all outputs 0; a subsequent switch sets switch_err.
